uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter BAUD_CNT, default 5208, giving the clock cycles per serial bit (50 MHz / 9600 baud); legal values are 2 or more.
REQ-002 The block SHALL have parameter PARITY_EN, default 0, where 1 inserts a parity bit after the data bits.
REQ-003 The block SHALL have parameter PARITY_ODD, default 0, where 0 selects even parity and 1 selects odd parity; it is ignored when PARITY_EN=0.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port tx_data, input, 8 bits: the byte to send.
REQ-007 The block SHALL have port tx_vld, input, 1 bit: request to send tx_data.
REQ-008 The block SHALL have port tx_rdy, output, 1 bit: the block can accept a byte.
REQ-009 The block SHALL have port tx_done, output, 1 bit: one-cycle pulse marking frame completion.
REQ-010 The block SHALL have port tx_uart, output, 1 bit: the serial line, idle high.

Function
REQ-011 The block SHALL implement an FSM with states IDLE, START, DATA, PARITY and STOP.
REQ-012 tx_rdy SHALL be 1 exactly when the state is IDLE.
REQ-013 A byte SHALL be accepted on the rising edge where tx_vld=1 and tx_rdy=1.
  - tx_data is captured into an internal shift register.
  - The state moves to START.
REQ-014 tx_vld SHALL be ignored while tx_rdy=0; changes on tx_data after acceptance SHALL NOT affect the frame in progress.
REQ-015 tx_uart SHALL be registered (no combinational path from any input); it becomes 0 in the cycle immediately after the accepting edge.
REQ-016 Bit timing SHALL come from a baud counter:
  - It counts 0..BAUD_CNT-1 in every non-IDLE state and wraps to 0 at the end of each bit.
  - Its width is ceil(log2(BAUD_CNT)).
  - It is held at 0 in IDLE.
REQ-017 Each line bit (start, 8 data, optional parity, stop) SHALL be driven for exactly BAUD_CNT cycles.
REQ-018 Data SHALL be sent LSB first, using a 3-bit bit index 0..7.
  - DATA exits after index 7 completes.
  - It goes to PARITY if PARITY_EN=1, otherwise to STOP.
REQ-019 The parity bit SHALL be the XOR of the 8 captured bits, inverted when PARITY_ODD=1.
REQ-020 The STOP state SHALL drive tx_uart=1 for BAUD_CNT cycles.
  - tx_done=1 in the last STOP cycle only.
  - The next state is IDLE.
REQ-021 The frame SHALL occupy exactly 10*BAUD_CNT cycles (11*BAUD_CNT with parity) from the first cycle of tx_uart=0 through the last STOP cycle.
REQ-022 The minimum accept-to-accept spacing SHALL be frame length + 1 cycle.
  - After STOP the block spends one cycle in IDLE with tx_uart=1.
  - This holds even if tx_vld is held high continuously.
REQ-023 tx_done and acceptance SHALL never occur in the same cycle.

Reset
REQ-024 While rst=1, regardless of clk, all outputs SHALL take their reset values:
  - state=IDLE
  - baud counter=0, bit index=0, shift register=0
  - tx_uart=1, tx_rdy=1, tx_done=0
REQ-025 Reset asserted mid-frame SHALL abort the frame.
  - tx_uart returns to 1 immediately.
  - No tx_done is produced for the aborted byte.
  - The first rising edge after rst deasserts with tx_vld=1 SHALL accept a new byte.

Verification
REQ-026 Single byte: BAUD_CNT=16, PARITY_EN=0, send 0x55.
  - tx_uart = 0,1,0,1,0,1,0,1,0,1 (start, LSB..MSB, stop), each held 16 cycles.
  - tx_done pulses once, at cycle 160 after acceptance.
  - tx_rdy returns high the next cycle.
REQ-027 Parity: BAUD_CNT=16, PARITY_EN=1, send 0xA3.
  - With PARITY_ODD=0, the parity bit is 0.
  - With PARITY_ODD=1, the parity bit is 1.
  - The frame length is 176 cycles.
REQ-028 Back-to-back: hold tx_vld=1 with 0x00 then 0xFF.
  - Exactly two frames are sent.
  - Between them there are 16 stop cycles plus 1 idle cycle at tx_uart=1.
  - Second start bit begins 161 cycles after the first.
REQ-029 Busy ignore: mid-frame, pulse tx_vld with tx_data=0x3C.
  - The serial output is unchanged.
  - No extra frame is sent.
  - tx_done pulses only once.
REQ-030 Reset mid-frame: assert rst during bit 4 of 0x81.
  - tx_uart=1 and tx_rdy=1 immediately.
  - No tx_done.
  - After release, 0x7E is sent correctly.
REQ-031 Default BAUD_CNT=5208: send 0x01.
  - The start bit lasts 5208 cycles.
  - The total frame is 52080 cycles.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter with optional even/odd parity.
// Handshake: a byte is accepted on a rising edge where tx_vld=1 and tx_rdy=1;
// tx_rdy is high only in IDLE, tx_vld is ignored otherwise, and tx_data is
// captured at acceptance so later changes do not affect the frame in flight.
// The serial line is driven from a register. tx_done marks the last STOP cycle.
module uart_tx #(
  parameter int unsigned BAUD_CNT   = 5208,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_vld,
  output logic       tx_rdy,
  output logic       tx_done,
  output logic       tx_uart,
  output logic [2:0] state_o
);

  localparam int CW = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_CNT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          bit_end;

  assign bit_end = (baud_q == BAUD_LAST);

  // Next-state logic: the line value for the next cycle is decided together
  // with the state transition so tx_uart stays a pure register output.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    if (state_q == S_IDLE) begin
      baud_d = '0;
      tx_d   = 1'b1;
    end else begin
      baud_d = bit_end ? '0 : baud_q + CW'(1);
    end
    case (state_q)
      S_IDLE: begin
        if (tx_vld) begin
          state_d = S_START;
          shift_d = tx_data;
          par_d   = (^tx_data) ^ PARITY_ODD;
          bit_d   = 3'd0;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            bit_d = 3'd0;
            if (PARITY_EN) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State, counters and line register; reset aborts any frame in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign tx_rdy  = (state_q == S_IDLE);
  assign tx_done = (state_q == S_STOP) && bit_end;
  assign tx_uart = tx_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (BAUD 16 plain, 16 even parity,
// 16 odd parity, default baud). Each cycle's expected {rdy,done,line} is
// queued when a byte is sent and compared on the falling clock edge.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_a [4];
  logic       vld_a  [4];
  logic       rdy_w  [4];
  logic       done_w [4];
  logic       line_w [4];
  logic [2:0] st_w   [4];

  logic [2:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx #(.BAUD_CNT(16), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_plain (
    .clk(clk), .rst(rst), .tx_data(data_a[0]), .tx_vld(vld_a[0]),
    .tx_rdy(rdy_w[0]), .tx_done(done_w[0]), .tx_uart(line_w[0]), .state_o(st_w[0]));
  uart_tx #(.BAUD_CNT(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_even (
    .clk(clk), .rst(rst), .tx_data(data_a[1]), .tx_vld(vld_a[1]),
    .tx_rdy(rdy_w[1]), .tx_done(done_w[1]), .tx_uart(line_w[1]), .state_o(st_w[1]));
  uart_tx #(.BAUD_CNT(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_odd (
    .clk(clk), .rst(rst), .tx_data(data_a[2]), .tx_vld(vld_a[2]),
    .tx_rdy(rdy_w[2]), .tx_done(done_w[2]), .tx_uart(line_w[2]), .state_o(st_w[2]));
  uart_tx u_dflt (
    .clk(clk), .rst(rst), .tx_data(data_a[3]), .tx_vld(vld_a[3]),
    .tx_rdy(rdy_w[3]), .tx_done(done_w[3]), .tx_uart(line_w[3]), .state_o(st_w[3]));

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Expected per-cycle {rdy,done,line} for one frame plus the idle cycle after it.
  task automatic push_frame(input int idx, input logic [7:0] d);
    int  baud;
    bit  pe, po;
    baud = (idx == 3) ? 5208 : 16;
    pe   = (idx == 1) || (idx == 2);
    po   = (idx == 2);
    repeat (baud) exp_q.push_back(3'b000);
    for (int i = 0; i < 8; i++) repeat (baud) exp_q.push_back({2'b00, d[i]});
    if (pe) repeat (baud) exp_q.push_back({2'b00, (^d) ^ po});
    repeat (baud - 1) exp_q.push_back(3'b001);
    exp_q.push_back(3'b011);
    exp_q.push_back(3'b101);
  endtask

  task automatic push_idle(input int n);
    repeat (n) exp_q.push_back(3'b101);
  endtask

  // Pop and compare n cycles of output from instance idx.
  task automatic cmp(input int idx, input int n, input string tag);
    logic [2:0] e;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL %s scoreboard empty observed=%b expected=entry", tag,
               {rdy_w[idx], done_w[idx], line_w[idx]});
      end else begin
        e = exp_q.pop_front();
        chk(tag, {rdy_w[idx], done_w[idx], line_w[idx]}, e);
      end
    end
  endtask

  // Present a byte while the block is idle; it is accepted on the next rising edge.
  task automatic accept(input int idx, input logic [7:0] d, input bit hold);
    @(negedge clk);
    chk("rdy_before_send", {2'b00, rdy_w[idx]}, 3'b001);
    vld_a[idx]  = 1'b1;
    data_a[idx] = d;
    @(posedge clk);
    #1;
    if (!hold) vld_a[idx] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vld_a[i]  = 1'b0;
      data_a[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("reset_outputs", {rdy_w[i], done_w[i], line_w[i]}, 3'b101);
      chk("reset_state", st_w[i], 3'd0);
    end
    rst = 1'b0;

    // Single byte 0x55, no parity.
    accept(0, 8'h55, 1'b0);
    push_frame(0, 8'h55);
    push_idle(4);
    cmp(0, 165, "single_55");

    // Parity, even and odd, byte 0xA3 (176-cycle frames).
    accept(1, 8'hA3, 1'b0);
    push_frame(1, 8'hA3);
    cmp(1, 177, "parity_even_a3");
    accept(2, 8'hA3, 1'b0);
    push_frame(2, 8'hA3);
    cmp(2, 177, "parity_odd_a3");

    // Back-to-back with tx_vld held high: 0x00 then 0xFF.
    accept(0, 8'h00, 1'b1);
    data_a[0] = 8'hFF;
    push_frame(0, 8'h00);
    push_frame(0, 8'hFF);
    cmp(0, 161, "b2b_first");
    @(posedge clk);
    #1;
    vld_a[0] = 1'b0;
    push_idle(5);
    cmp(0, 166, "b2b_second");

    // Busy ignore: a request while busy must not disturb the frame.
    accept(0, 8'hC5, 1'b0);
    push_frame(0, 8'hC5);
    push_idle(20);
    cmp(0, 50, "busy_before");
    vld_a[0]  = 1'b1;
    data_a[0] = 8'h3C;
    cmp(0, 1, "busy_pulse");
    vld_a[0]  = 1'b0;
    cmp(0, 130, "busy_after");

    // Reset during data bit 4 of 0x81, then send 0x7E.
    accept(0, 8'h81, 1'b0);
    push_frame(0, 8'h81);
    cmp(0, 85, "abort_pre");
    #2;
    rst = 1'b1;
    #1;
    chk("abort_async", {rdy_w[0], done_w[0], line_w[0]}, 3'b101);
    chk("abort_state", st_w[0], 3'd0);
    exp_q.delete();
    push_idle(3);
    cmp(0, 3, "in_reset");
    rst       = 1'b0;
    vld_a[0]  = 1'b1;
    data_a[0] = 8'h7E;
    @(posedge clk);
    #1;
    vld_a[0]  = 1'b0;
    push_frame(0, 8'h7E);
    cmp(0, 161, "after_reset_7e");

    // Default baud, byte 0x01: 52080-cycle frame.
    accept(3, 8'h01, 1'b0);
    push_frame(3, 8'h01);
    cmp(3, 52081, "default_baud_01");

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
